// File: rtl/aes_cipher_iter_if.sv
// Block handshake for the iterative AES core: plaintext in, ciphertext out,
// valid/ready on both sides.
interface aes_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] ciphertext;

  modport master (output in_valid, plaintext, out_ready,
                  input  in_ready, out_valid, ciphertext);
  modport slave  (input  in_valid, plaintext, out_ready,
                  output in_ready, out_valid, ciphertext);
endinterface

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption: one full round per clock over a 128-bit state
// register, round keys taken live from the externally expanded schedule.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = TBL[{a, 3'b000} +: 8];
endmodule

module aes_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [0:32*(4*Nr+4)-1]   w,
  aes_cipher_iter_if.slave         io
);
  localparam logic [3:0] LAST = 4'(Nr);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm;
  logic [3:0]   rnd;
  logic [0:127] st_q, sb, sr, mc, rkey, nxt;
  logic         in_ready_q, out_valid_q;

  // Nk only documents the key size; the schedule width already encodes it.
  if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_nk_nonstandard
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [0:31] mixcol(input logic [0:31] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_lane
    aes_sbox u_sbox (.a(st_q[8*i +: 8]), .y(sb[8*i +: 8]));
  end

  // State is column-major: byte 4c+r sits at row r, column c.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
    end
    assign mc[32*c +: 32] = mixcol(sr[32*c +: 32]);
  end

  assign rkey = w[128*int'(rnd) +: 128];
  assign nxt  = ((rnd == LAST) ? sr : mc) ^ rkey;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      rnd         <= '0;
      st_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (io.in_valid && in_ready_q) begin
            st_q       <= io.plaintext ^ w[0:127];
            rnd        <= 4'd1;
            in_ready_q <= 1'b0;
            fsm        <= ROUND;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ROUND: begin
          st_q <= nxt;
          if (rnd == LAST) begin
            out_valid_q <= 1'b1;
            fsm         <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          // Ready reappears only after the handoff edge, so blocks never overlap.
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            rnd         <= '0;
            fsm         <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign io.in_ready   = in_ready_q;
  assign io.out_valid  = out_valid_q;
  assign io.ciphertext = st_q;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: AES-128/192/256 instances checked against FIPS-197
// vectors and a table-free behavioural AES model with random keys/blocks.
module tb_aes_cipher_iter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         out_ready;
  logic [0:127] plaintext;
  logic         iv  [3];
  logic         rdy [3];
  logic         ov  [3];
  logic [0:127] ct  [3];
  logic [0:1407] w10;
  logic [0:1663] w12;
  logic [0:1919] w14;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [7:0] sbt [256];

  localparam logic [0:127] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:255] K_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] K_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K_192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] K_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_iter_if if10 ();
  aes_cipher_iter_if if12 ();
  aes_cipher_iter_if if14 ();

  assign if10.in_valid = iv[0]; assign if10.plaintext = plaintext; assign if10.out_ready = out_ready;
  assign if12.in_valid = iv[1]; assign if12.plaintext = plaintext; assign if12.out_ready = out_ready;
  assign if14.in_valid = iv[2]; assign if14.plaintext = plaintext; assign if14.out_ready = out_ready;
  assign rdy[0] = if10.in_ready; assign ov[0] = if10.out_valid; assign ct[0] = if10.ciphertext;
  assign rdy[1] = if12.in_ready; assign ov[1] = if12.out_valid; assign ct[1] = if12.ciphertext;
  assign rdy[2] = if14.in_ready; assign ov[2] = if14.out_valid; assign ct[2] = if14.ciphertext;

  aes_cipher_iter #(.Nk(4), .Nr(10)) dut10 (.clk(clk), .rst_n(rst_n), .w(w10), .io(if10));
  aes_cipher_iter #(.Nk(6), .Nr(12)) dut12 (.clk(clk), .rst_n(rst_n), .w(w12), .io(if12));
  aes_cipher_iter #(.Nk(8), .Nr(14)) dut14 (.clk(clk), .rst_n(rst_n), .w(w14), .io(if14));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(logic [7:0] b, int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from the definition: multiplicative inverse then affine map.
  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  function automatic logic [0:1919] keyexp(logic [0:255] key, int nk, int nr);
    logic [31:0] wd [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [0:1919] s;
    rc = 8'h01;
    s  = '0;
    for (int i = 0; i < nk; i++) wd[i] = key[32*i +: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = wd[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      wd[i] = wd[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) s[32*i +: 32] = wd[i];
    return s;
  endfunction

  function automatic logic [0:127] enc(logic [0:1919] s, int nr, logic [0:127] pt);
    logic [7:0] a [4][4];
    logic [7:0] b [4][4];
    logic [0:127] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = pt[8*(r+4*c) +: 8] ^ s[8*(r+4*c) +: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          b[r][c] = sbt[a[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          a[r][c] = (rd < nr) ? (gm(b[r][c], 8'h02) ^ gm(b[(r+1)%4][c], 8'h03) ^
                                 b[(r+2)%4][c] ^ b[(r+3)%4][c]) : b[r][c];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          a[r][c] ^= s[128*rd + 8*(r+4*c) +: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = a[r][c];
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_key(int k, logic [0:255] key, output logic [0:1919] sched);
    sched = keyexp(key, 4 + 2*k, 10 + 2*k);
    case (k)
      0:       w10 = sched[0:1407];
      1:       w12 = sched[0:1663];
      default: w14 = sched;
    endcase
  endtask

  task automatic wait_rdy(int k, string tag);
    int n = 0;
    while (!rdy[k] && n < 64) begin @(posedge clk); #1; n++; end
    chk({tag, ".rdy"}, 128'(rdy[k]), 128'd1);
  endtask

  task automatic wait_ov(int k, output int n);
    n = 0;
    while (!ov[k] && n < 64) begin @(posedge clk); #1; n++; end
  endtask

  task automatic xfer(int k, logic [0:127] pt, logic [0:127] exp, string tag);
    int n;
    plaintext = pt; out_ready = 1'b1; iv[k] = 1'b1;
    wait_rdy(k, tag);
    @(posedge clk); #1; iv[k] = 1'b0;
    chk({tag, ".busy"}, 128'(rdy[k]), 128'd0);
    wait_ov(k, n);
    chk({tag, ".lat"}, 128'(n), 128'(10 + 2*k));
    chk({tag, ".ct"}, ct[k], exp);
    chk({tag, ".hand_rdy"}, 128'(rdy[k]), 128'd0);
    @(posedge clk); #1;
    chk({tag, ".ov_clr"}, 128'(ov[k]), 128'd0);
    chk({tag, ".rdy_back"}, 128'(rdy[k]), 128'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:1919] sched;
    logic [0:255]  key;
    logic [0:127]  pt;
    int n, a2, h;

    init_sbox();
    iv[0] = 0; iv[1] = 0; iv[2] = 0;
    rst_n = 0; out_ready = 0; plaintext = '0;
    w10 = '0; w12 = '0; w14 = '0;

    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset.ov",  128'(ov[k]),  128'd0);
      chk("reset.ct",  ct[k],        128'd0);
      chk("reset.rdy", 128'(rdy[k]), 128'd0);
    end
    @(negedge clk) rst_n = 1;

    // FIPS-197 vectors
    set_key(0, K_C1, sched);  xfer(0, PT_C1, CT_C1, "c1");
    set_key(0, K_B, sched);   xfer(0, PT_B, CT_B, "appb");
    set_key(1, K_192, sched); xfer(1, PT_C1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "aes192");
    set_key(2, K_256, sched); xfer(2, PT_C1, 128'h8ea2b7ca516745bfeafc49904b496089, "aes256");

    // random keys and blocks against the model
    for (int i = 0; i < 12; i++) begin
      int k;
      k   = (i < 8) ? 0 : (i < 10 ? 1 : 2);
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      if (k == 0) key[128:255] = '0;
      if (k == 1) key[192:255] = '0;
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      set_key(k, key, sched);
      xfer(k, pt, enc(sched, 10 + 2*k, pt), "rand");
    end

    // backpressure: result held, second request ignored
    set_key(0, K_C1, sched);
    plaintext = PT_C1; out_ready = 0; iv[0] = 1;
    wait_rdy(0, "bp");
    @(posedge clk); #1; iv[0] = 0;
    wait_ov(0, n);
    chk("bp.lat", 128'(n), 128'd10);
    for (int i = 0; i < 20; i++) begin
      chk("bp.ov",  128'(ov[0]),  128'd1);
      chk("bp.ct",  ct[0],        CT_C1);
      chk("bp.rdy", 128'(rdy[0]), 128'd0);
      iv[0] = (i == 5);
      if (i == 5) plaintext = PT_B;
      @(posedge clk); #1;
    end
    iv[0] = 0; out_ready = 1;
    chk("bp.hand_ov",  128'(ov[0]),  128'd1);
    chk("bp.hand_rdy", 128'(rdy[0]), 128'd0);
    @(posedge clk); #1;
    chk("bp.ov_clr",   128'(ov[0]),  128'd0);
    chk("bp.rdy_back", 128'(rdy[0]), 128'd1);
    repeat (3) @(posedge clk); #1;
    chk("bp.no_queue", 128'(ov[0]),  128'd0);

    // reset in the middle of a block
    plaintext = PT_C1; iv[0] = 1;
    wait_rdy(0, "rst");
    @(posedge clk); #1; iv[0] = 0;
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("rst.ov",  128'(ov[0]),  128'd0);
    chk("rst.ct",  ct[0],        128'd0);
    chk("rst.rdy", 128'(rdy[0]), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (2) @(posedge clk); #1;
    chk("rst.rdy_after", 128'(rdy[0]), 128'd1);
    xfer(0, PT_C1, CT_C1, "rst_resub");

    // back-to-back with in_valid held high
    plaintext = PT_C1; out_ready = 1; iv[0] = 1;
    wait_rdy(0, "b2b1");
    @(posedge clk); #1;
    wait_ov(0, n);
    chk("b2b1.lat", 128'(n), 128'd10);
    chk("b2b1.ct", ct[0], CT_C1);
    set_key(0, K_B, sched);
    plaintext = PT_B;
    @(posedge clk); #1; h = cyc;
    wait_rdy(0, "b2b2");
    @(posedge clk); #1; a2 = cyc; iv[0] = 0;
    chk("b2b.gap", 128'(a2 - h), 128'd1);
    wait_ov(0, n);
    chk("b2b2.lat", 128'(n), 128'd10);
    chk("b2b2.ct", ct[0], CT_B);
    @(posedge clk); #1;
    chk("b2b2.ov_clr", 128'(ov[0]), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
